// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: sequential adder/subtractor controller. It feeds WIDTH/SLICE
// beats of operand slices through an external combinational carry-lookahead
// slice and stitches the results into a WIDTH-bit sum.
// Optional feature macro: ADD_SEQ_CTRL_OVF_EN enables signed-overflow output;
// without it ovf is tied to 0.
module add_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  input  logic [SLICE-1:0] slice_sum,
  input  logic             slice_cout
);

  localparam int NBEATS = WIDTH / SLICE;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // The subtract request is fully captured by the inverted B operand and the
  // initial carry, so no separate flag is needed after acceptance.
  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              cout_q;
  logic [BEAT_W-1:0] beat_q;

  logic accept;
  logic last_beat;

  assign accept    = (state_q == S_IDLE) && start;
  assign last_beat = (state_q == S_RUN) && (beat_q == LAST_BEAT);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: a default assignment first keeps every path assigned, so no latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (beat_q == LAST_BEAT) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registers only; slices are zero outside RUN.
  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    case (state_q)
      S_IDLE: ready = 1'b1;
      S_RUN: begin
        slice_a   = op_a_q[beat_q*SLICE +: SLICE];
        slice_b   = op_b_q[beat_q*SLICE +: SLICE];
        slice_cin = carry_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on accept, then one slice result written per RUN beat.
  // NOTE: every datapath flop is reset here; there is no memory array, so
  // a full reset costs nothing and gives a clean post-reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      beat_q  <= '0;
    end else if (accept) begin
      op_a_q  <= a;
      op_b_q  <= b ^ {WIDTH{sub}};
      carry_q <= sub;
      beat_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (state_q == S_RUN) begin
      sum_q[beat_q*SLICE +: SLICE] <= slice_sum;
      carry_q <= slice_cout;
      if (last_beat) begin
        beat_q <= '0;
        cout_q <= slice_cout;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef ADD_SEQ_CTRL_OVF_EN
  logic ovf_q;

  // Signed overflow: operands agree in sign but the result's sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovf_q <= 1'b0;
    else if (accept)    ovf_q <= 1'b0;
    else if (last_beat) ovf_q <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                                 (slice_sum[SLICE-1] != op_a_q[WIDTH-1]);
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl at default parameters. The external
// carry-lookahead slice is modelled as a plain combinational adder.
module tb_add_seq_ctrl;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NBEATS = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ready, done, cout, ovf, slice_cin, slice_cout;
  logic [WIDTH-1:0] sum;
  logic [SLICE-1:0] slice_a, slice_b, slice_sum;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  add_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, slice_cin};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on full-width integers.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic msub);
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    longint           sr;
    if (msub) begin
      r  = ma - mb;
      c  = (ma >= mb);
      sr = longint'($signed(ma)) - longint'($signed(mb));
    end else begin
      r  = ma + mb;
      c  = ((longint'(ma) + longint'(mb)) >> WIDTH) != 0;
      sr = longint'($signed(ma)) + longint'($signed(mb));
    end
`ifdef ADD_SEQ_CTRL_OVF_EN
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`else
    v = 1'b0;
`endif
    return {v, c, r};
  endfunction

  // Issue one operation in the first cycle ready is seen, then follow it to
  // the done pulse. Called and returning on a falling edge.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic isub,
                        output logic [WIDTH-1:0] osum, output logic ocout, output logic oovf,
                        output int acc_cyc);
    int guard;
    int lat;
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check("ready_timeout", 64'(ready), 64'd1);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    acc_cyc = cyc;
    a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    @(negedge clk);
    check("run_ready_low", 64'(ready), 64'd0);
    check("sum_cleared", {31'd0, cout, sum}, 64'd0);
    check("beat0_cin", 64'(slice_cin), 64'(isub));
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    check("done_latency", 64'(lat), 64'(NBEATS));
    osum = sum; ocout = cout; oovf = ovf;
    @(negedge clk);
    check("done_one_cycle", {62'd0, done, ready}, 64'd1);
    check("result_held", 64'(sum), 64'(osum));
  endtask

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf_en;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [WIDTH-1:0] rs;
    logic             rc, rv, exp_ovf;
    logic [WIDTH+1:0] m;
    int               acc, prev_acc, n_done;

    vecs[0] = '{"carry_ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{"wrap_add",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{"sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{"sub_noborrow", 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4] = '{"signed_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};

    // Reset state.
    #2;
    check("rst_ready_done", {62'd0, ready, done}, 64'd2);
    check("rst_results", {30'd0, ovf, cout, sum}, 64'd0);
    check("rst_slices", {47'd0, slice_cin, slice_a, slice_b}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back to back.
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, rv, acc);
`ifdef ADD_SEQ_CTRL_OVF_EN
      exp_ovf = vecs[i].ovf_en;
`else
      exp_ovf = 1'b0;
`endif
      check({vecs[i].name, "_sum"}, 64'(rs), 64'(vecs[i].sum));
      check({vecs[i].name, "_cout"}, 64'(rc), 64'(vecs[i].cout));
      check({vecs[i].name, "_ovf"}, 64'(rv), 64'(exp_ovf));
      if (i > 0) check("b2b_throughput", 64'(acc - prev_acc), 64'(NBEATS + 2));
      prev_acc = acc;
    end
    check("idle_slices", {47'd0, slice_cin, slice_a, slice_b}, 64'd0);

    // Start during RUN is ignored.
    a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    a = 32'h0000_FFFF; b = 32'h0000_FFFF; start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("ignored_start_pulses", 64'(n_done), 64'd1);
    check("ignored_start_sum", 64'(sum), 64'h2);

    // Reset during beat 2 aborts without a done pulse.
    a = 32'h1234_5678; b = 32'h0F0F_0F0F; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {62'd0, ready, done}, 64'd2);
    check("abort_sum", {30'd0, ovf, cout, sum}, 64'd0);
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    run_op(32'd3, 32'd4, 1'b0, rs, rc, rv, acc);
    check("post_abort_sum", 64'(rs), 64'd7);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rsub;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = 32'h7FFF_FFFF ^ (32'($urandom_range(0, 3)));
        1: rb = 32'h8000_0000 | (32'($urandom_range(0, 3)));
        default: ;
      endcase
      rsub = $urandom_range(0, 1);
      run_op(ra, rb, rsub, rs, rc, rv, acc);
      m = model(ra, rb, rsub);
      check("rand_result", {30'd0, rv, rc, rs}, {30'd0, m});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("rand_hold", 64'(sum), 64'(rs));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 The block SHALL have parameters: WIDTH, default 32, operand width; SLICE, default 8, width of the external carry-lookahead adder slice; WIDTH SHALL be an integer multiple of SLICE.
REQ-002 The block SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only when ready=1.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- ready  out  1  block idle, will accept start.
- done  out  1  one-cycle pulse, result valid.
- sum  out  WIDTH  result, held until next accepted start.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow (see Configuration).
- slice_a  out  SLICE  operand A slice to external CLA.
- slice_b  out  SLICE  effective operand B slice to external CLA.
- slice_cin  out  1  carry in to external CLA.
- slice_sum  in  SLICE  combinational sum from external CLA.
- slice_cout  in  1  combinational carry out from external CLA.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-004 IDLE: ready=1; on start=1 at a rising edge it SHALL register a, b XOR {WIDTH{sub}}, carry register = sub, beat = 0, sub flag, and go to RUN.
REQ-005 RUN: ready=0; slice_a, slice_b SHALL be bits [beat*SLICE +: SLICE] of the registered operands, slice_cin = carry register, all driven from registers only (no combinational path from a, b, start).
REQ-006 RUN: each rising edge SHALL write slice_sum into sum[beat*SLICE +: SLICE], load carry register from slice_cout, and increment beat.
REQ-007 RUN: on the edge capturing the last beat (WIDTH/SLICE-1), the FSM SHALL go to DONE and cout SHALL take slice_cout.
REQ-008 Latency: with start sampled at edge N, done SHALL be 1 in the cycle following edge N+WIDTH/SLICE (edge N+4 at defaults) for exactly one cycle; DONE then SHALL return to IDLE on the next edge.
REQ-009 start while ready=0 (RUN or DONE) SHALL be ignored with no effect on operands, sum or state.
REQ-010 Back-to-back: start asserted in the first IDLE cycle after DONE SHALL be accepted; throughput is one operation per WIDTH/SLICE+2 cycles.
REQ-011 sum, cout, ovf SHALL hold their final values from DONE until the edge that accepts the next start; they SHALL be cleared to 0 on that edge before slice results are written.
REQ-012 Outside RUN, slice_a, slice_b and slice_cin SHALL be driven to 0.
REQ-013 Arithmetic SHALL be modulo 2^WIDTH; the carry chain SHALL propagate only through the carry register between beats.

Reset
REQ-014 rst_n=0 SHALL immediately, asynchronously, set state=IDLE, beat=0, carry=0, operands=0, sum=0, cout=0, ovf=0, done=0, ready=1.
REQ-015 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; first start after release SHALL be accepted normally.

Configuration
REQ-016 Macro ADD_SEQ_CTRL_OVF_EN: when defined, ovf SHALL be registered on the last-beat edge as (A[MSB] == Beff[MSB]) AND (sum[MSB] != A[MSB]), Beff being the inverted-for-sub operand; when undefined, ovf SHALL be tied to 0 and no overflow logic synthesized.

Verification
REQ-017 a=0x000000FF, b=0x00000001, sub=0 -> done 4 cycles after start, sum=0x00000100, cout=0, ovf=0.
REQ-018 a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, ovf=0.
REQ-019 a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0; then a=7, b=5, sub=1 back-to-back -> sum=0x00000002, cout=1.
REQ-020 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1 with ADD_SEQ_CTRL_OVF_EN defined, ovf=0 without.
REQ-021 start with a=1, b=1; second start with a=0xFFFF, b=0xFFFF two cycles later -> second ignored, sum=0x00000002, single done pulse.
REQ-022 rst_n pulsed low during beat 2 -> no done, sum=0, ready=1 immediately; next start a=3, b=4 -> sum=0x00000007.
